module_seg7_scan: RTL

- Seven-segment scan driver, directly downstream of the 27 MHz frequency divider.
- Consumes the divider's 1-cycle refresh tick and steps a one-hot anode through NUM_DIGITS digits.
- Decodes each hex nibble to segments and inserts a dead-time (all digits off) between digits to prevent ghosting.
- New digit values are accepted by a valid/ready handshake and applied only at a frame boundary, so a frame never mixes old and new data.

---
 rtl/module_seg7_scan.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/module_seg7_scan.sv
// ---------------------------------------------------------------------------
// module_seg7_scan
//
// Multiplexed seven-segment scan driver. It sits behind the 27 MHz divider,
// steps a one-hot anode through NUM_DIGITS digits on each refresh tick, decodes
// each hex nibble to segments, and holds every output off for BLANK_CYCLES
// clocks before each digit lights up, which prevents ghosting between digits.
// New digit data is accepted through a valid/ready handshake. It is parked in
// a shadow register and moved to the display only when the scan wraps back to
// digit 0, so a single frame never shows a mix of old and new data.
//
// Parameters:
//   NUM_DIGITS     number of multiplexed digits (2..8)
//   BLANK_CYCLES   all-off clocks before each digit is shown (>=1)
//   AN_ACTIVE_LOW  1 = anode outputs are active-low
//   SEG_ACTIVE_LOW 1 = segment/dp outputs are active-low
//
// Ports:
//   clk          system clock (27 MHz)
//   rst          synchronous reset, active-high
//   scan_tick_i  1-cycle refresh pulse; only acted on while a digit is shown
//   digits_i     hex nibbles, nibble k drives digit k (digit 0 = LS digit)
//   dp_i         decimal-point enables, bit k drives digit k
//   valid_i      new digits_i/dp_i offered
//   ready_o      high when no update is waiting for the next frame wrap
//   an_o         digit enables, one-hot while a digit is shown
//   seg_o        segments {g,f,e,d,c,b,a}
//   dp_o         decimal point
//   frame_o      1-cycle pulse after the scan index wraps to 0
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits k>0 that are zero and have only
//                          zero digits above them show no segments (their
//                          anode still cycles and dp still follows dp[k]).
// ---------------------------------------------------------------------------
module module_seg7_scan #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned BLANK_CYCLES   = 64,
    parameter int unsigned AN_ACTIVE_LOW  = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scan_tick_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLANK_CYCLES - 1);

    // Inactive output levels for the configured polarities.
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0)  ? '1 : '0;
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;

    logic [4*NUM_DIGITS-1:0] disp_digits;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    pending;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Per-digit "suppress segments" mask for leading zeros.
    logic [NUM_DIGITS-1:0] lz_mask;

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Walk down from the most significant digit; a digit is a leading zero
    // while it and everything above it are zero. Digit 0 is never suppressed.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero & (disp_digits[4*k +: 4] == 4'h0);
            lz_mask[k] = upper_zero;
        end
    end
`else
    always_comb begin
        lz_mask = '0;
    end
`endif

    // Drive levels for the digit selected by idx, already polarity-adjusted.
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic [6:0]            cur_seg;
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] an_show;
    logic [6:0]            seg_show;
    logic                  dp_show;

    always_comb begin
        cur_nib  = disp_digits[{idx, 2'b00} +: 4];
        cur_dp   = disp_dp[idx];
        cur_seg  = lz_mask[idx] ? 7'h00 : decode(cur_nib);
        onehot   = NUM_DIGITS'(1) << idx;
        an_show  = (AN_ACTIVE_LOW != 0)  ? ~onehot : onehot;
        seg_show = (SEG_ACTIVE_LOW != 0) ? ~cur_seg : cur_seg;
        dp_show  = (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
    end

    // Handshake and frame-wrap qualifiers.
    logic wrap;
    logic take;
    logic pending_next;

    always_comb begin
        wrap = (state == SHOW) && scan_tick_i && (idx == LAST_IDX);
        take = valid_i && !pending;
        // take needs pending=0 and a wrap only clears a set pending, so the
        // two never act on the same edge.
        pending_next = take | (pending & ~wrap);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BLANK;
            cnt           <= '0;
            idx           <= '0;
            disp_digits   <= '0;
            disp_dp       <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            pending       <= 1'b0;
            ready_o       <= 1'b1;
            frame_o       <= 1'b0;
            an_o          <= AN_OFF;
            seg_o         <= SEG_OFF;
            dp_o          <= DP_OFF;
        end else begin
            frame_o <= 1'b0;
            pending <= pending_next;
            ready_o <= ~pending_next;

            if (take) begin
                shadow_digits <= digits_i;
                shadow_dp     <= dp_i;
            end

            case (state)
                BLANK: begin
                    // Ticks arriving during dead time are dropped, not queued.
                    if (cnt == LAST_CNT) begin
                        state <= SHOW;
                        cnt   <= '0;
                        an_o  <= an_show;
                        seg_o <= seg_show;
                        dp_o  <= dp_show;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SHOW: begin
                    if (scan_tick_i) begin
                        state <= BLANK;
                        an_o  <= AN_OFF;
                        seg_o <= SEG_OFF;
                        dp_o  <= DP_OFF;
                        if (idx == LAST_IDX) begin
                            idx     <= '0;
                            frame_o <= 1'b1;
                            if (pending) begin
                                disp_digits <= shadow_digits;
                                disp_dp     <= shadow_dp;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
